// File: rtl/reg_dep_tracker.sv
// reg_dep_tracker
//   Decodes the Y86 source and destination register IDs of the instruction in decode.
//   Carries each instruction's dstE/dstM through a DEPTH-stage shadow pipe (E..W).
//   From that pipe it produces the bypass selects for both sources and the load-use stall.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   d_valid             decode slot holds a real instruction
//   d_icode, d_ifun     decode-stage icode/ifun
//   d_rA, d_rB          register fields
//   e_cnd               condition result for the instruction in stage 0 (E)
//   flush               squash: the decode slot does not enter E
//   d_srcA, d_srcB      decoded source registers (combinational)
//   fwdA_sel, fwdB_sel  bypass selects:
//                         0      register file
//                         1      E valE
//                         2*i    stage i valM
//                         2*i+1  stage i valE
//   stall               load-use stall: hold F/D, bubble into E
//   dstE_vec, dstM_vec  per-stage destinations, stage i at [i*REG_WID +: REG_WID]

module reg_dep_tracker #(
   parameter int unsigned          REG_WID = 4,
   parameter int unsigned          DEPTH   = 3,
   parameter logic [REG_WID-1:0]   NONE_ID = {REG_WID{1'b1}},
   parameter logic [REG_WID-1:0]   RSP_ID  = REG_WID'(4),
   localparam int unsigned         FWD_W   = $clog2(2*DEPTH+1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       d_valid,
   input  logic [3:0]                 d_icode,
   input  logic [3:0]                 d_ifun,
   input  logic [REG_WID-1:0]         d_rA,
   input  logic [REG_WID-1:0]         d_rB,
   input  logic                       e_cnd,
   input  logic                       flush,
   output logic [REG_WID-1:0]         d_srcA,
   output logic [REG_WID-1:0]         d_srcB,
   output logic [FWD_W-1:0]           fwdA_sel,
   output logic [FWD_W-1:0]           fwdB_sel,
   output logic                       stall,
   output logic [DEPTH*REG_WID-1:0]   dstE_vec,
   output logic [DEPTH*REG_WID-1:0]   dstM_vec
);

   localparam logic [3:0] ic_halt   = 4'h0;
   localparam logic [3:0] ic_nop    = 4'h1;
   localparam logic [3:0] ic_cmovxx = 4'h2;
   localparam logic [3:0] ic_irmovq = 4'h3;
   localparam logic [3:0] ic_rmmovq = 4'h4;
   localparam logic [3:0] ic_mrmovq = 4'h5;
   localparam logic [3:0] ic_opq    = 4'h6;
   localparam logic [3:0] ic_jxx    = 4'h7;
   localparam logic [3:0] ic_call   = 4'h8;
   localparam logic [3:0] ic_ret    = 4'h9;
   localparam logic [3:0] ic_pushq  = 4'hA;
   localparam logic [3:0] ic_popq   = 4'hB;

   typedef logic [DEPTH-1:0][REG_WID-1:0] stage_vec_t;

   logic [REG_WID-1:0] src_a, src_b, dst_e, dst_m;
   logic               is_cmov;

   stage_vec_t         dste_q, dste_d, dstm_q, dstm_d, dste_eff;
   logic               cmov_q, cmov_d;
   logic [REG_WID-1:0] dste0_eff;
   logic               take;

   // Decode of the instruction in the D slot
   always_comb begin
      src_a   = NONE_ID;
      src_b   = NONE_ID;
      dst_e   = NONE_ID;
      dst_m   = NONE_ID;
      is_cmov = 1'b0;
      if (d_valid) begin
         case (d_icode)
            ic_halt, ic_nop, ic_jxx: ;
            ic_cmovxx: begin
               src_a   = d_rA;
               dst_e   = d_rB;
               is_cmov = (d_ifun != 4'h0);
            end
            ic_irmovq: dst_e = d_rB;
            ic_rmmovq: begin
               src_a = d_rA;
               src_b = d_rB;
            end
            ic_mrmovq: begin
               src_b = d_rB;
               dst_m = d_rA;
            end
            ic_call: begin
               src_b = RSP_ID;
               dst_e = RSP_ID;
            end
            ic_ret: begin
               src_a = RSP_ID;
               src_b = RSP_ID;
               dst_e = RSP_ID;
            end
            ic_pushq: begin
               src_a = d_rA;
               src_b = RSP_ID;
               dst_e = RSP_ID;
            end
            ic_popq: begin
               src_a = RSP_ID;
               src_b = RSP_ID;
               dst_e = RSP_ID;
               dst_m = d_rA;
            end
            // ic_opq and unassigned icodes: generic rA/rB behaviour
            default: begin
               src_a = d_rA;
               src_b = d_rB;
               dst_e = d_rB;
            end
         endcase
      end
   end

   // A conditional move whose condition failed writes nothing
   assign dste0_eff = (cmov_q && !e_cnd) ? NONE_ID : dste_q[0];

   always_comb begin
      dste_eff    = dste_q;
      dste_eff[0] = dste0_eff;
   end

   // dstM in E has no value yet, so any reader of it must wait a cycle
   assign stall = d_valid && !flush && (dstm_q[0] != NONE_ID) &&
                  ((dstm_q[0] == src_a) || (dstm_q[0] == src_b));

   assign take = d_valid && !stall && !flush;

   // Walk oldest to youngest so the youngest hit overwrites; valM checked after valE
   // within a stage so dstM wins when both name the same register.
   function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_WID-1:0] src,
                                                 input stage_vec_t      e_vec,
                                                 input stage_vec_t      m_vec);
      logic [FWD_W-1:0] sel;
      sel = '0;
      if (src != NONE_ID) begin
         for (int i = DEPTH - 1; i >= 1; i--) begin
            if (e_vec[i] == src) sel = FWD_W'(2 * i + 1);
            if (m_vec[i] == src) sel = FWD_W'(2 * i);
         end
         if (e_vec[0] == src) sel = FWD_W'(1);
      end
      return sel;
   endfunction

   assign fwdA_sel = fwd_sel(src_a, dste_eff, dstm_q);
   assign fwdB_sel = fwd_sel(src_b, dste_eff, dstm_q);

   assign d_srcA   = src_a;
   assign d_srcB   = src_b;
   assign dstE_vec = dste_eff;
   assign dstM_vec = dstm_q;

   // Stages past E never stall; the resolved stage-0 dstE is what moves on
   always_comb begin
      dste_d = {dste_eff[DEPTH-2:0], (take ? dst_e : NONE_ID)};
      dstm_d = {dstm_q[DEPTH-2:0], (take ? dst_m : NONE_ID)};
      cmov_d = take && is_cmov;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dste_q <= {DEPTH{NONE_ID}};
         dstm_q <= {DEPTH{NONE_ID}};
         cmov_q <= 1'b0;
      end else begin
         dste_q <= dste_d;
         dstm_q <= dstm_d;
         cmov_q <= cmov_d;
      end
   end

endmodule
